// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants and decoder state encoding.
// Used by both the transmitter and the receiver so their timing stays consistent.
package ws2812_pkg;

  localparam int unsigned T0H  = 19;
  localparam int unsigned T1H  = 38;
  localparam int unsigned TBIT = 60;

  localparam int unsigned T_MIN_HIGH_DEF = 8;
  localparam int unsigned T_THRESH_DEF   = 29;
  localparam int unsigned T_MAX_HIGH_DEF = 60;
  localparam int unsigned T_RESET_DEF    = 2400;
  localparam int unsigned IDX_W_DEF      = 9;

  localparam int unsigned RGB_W = 24;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus one history flop.
// Provides the synchronized level and single-cycle rise/fall strobes.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_c  = sync_q & ~prev_q;
  assign fall_c  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire decoder: classifies high pulses by width, packs 24-bit
// words MSB first and reports the low-time latch that ends each frame.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned T_MIN_HIGH = T_MIN_HIGH_DEF,
  parameter int unsigned T_THRESH   = T_THRESH_DEF,
  parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_DEF,
  parameter int unsigned T_RESET    = T_RESET_DEF,
  parameter int unsigned IDX_W      = IDX_W_DEF
) (
  input  logic             clk_sb,
  input  logic             reset_n,
  input  logic             din,
  output logic [RGB_W-1:0] rgb_data,
  output logic             rgb_valid,
  output logic [IDX_W-1:0] led_index,
  output logic             frame_done,
  output logic [IDX_W-1:0] frame_leds,
  output logic             err_timing,
  output logic             err_partial
);

  localparam int unsigned CNT_W = $clog2(T_RESET + 1);
  localparam int unsigned BIT_W = $clog2(RGB_W + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(T_RESET);

  logic line_lvl;
  logic rise_c;
  logic fall_c;

  sync_edge u_sync (
    .clk     (clk_sb),
    .rst_n   (reset_n),
    .d_i     (din),
    .level_o (line_lvl),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [RGB_W-1:0] shift_q;
  logic [BIT_W-1:0] nbits_q;
  logic [IDX_W-1:0] idx_q;
  logic             word_q;

  logic [RGB_W-1:0] rgb_data_q;
  logic             rgb_valid_q;
  logic [IDX_W-1:0] led_index_q;
  logic             frame_done_q;
  logic [IDX_W-1:0] frame_leds_q;
  logic             err_timing_q;
  logic             err_partial_q;

  // cnt_q holds the cycles of the current level seen before this one
  always_comb begin
    cnt_d = cnt_q;
    if (rise_c || fall_c) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SYNC;
      cnt_q         <= '0;
      shift_q       <= '0;
      nbits_q       <= '0;
      idx_q         <= '0;
      word_q        <= 1'b0;
      rgb_data_q    <= '0;
      rgb_valid_q   <= 1'b0;
      led_index_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_leds_q  <= '0;
      err_timing_q  <= 1'b0;
      err_partial_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      word_q        <= 1'b0;
      rgb_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timing_q  <= 1'b0;
      err_partial_q <= 1'b0;

      // Publish a completed word one cycle after its last bit
      if (word_q) begin
        rgb_data_q  <= shift_q;
        led_index_q <= idx_q;
        rgb_valid_q <= 1'b1;
        if (idx_q != '1) begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end

      case (state_q)
        SYNC: begin
          // Join only after a full latch so bits stay word-aligned
          if (!line_lvl && cnt_q >= CNT_W'(T_RESET - 1)) begin
            state_q <= LOW;
            nbits_q <= '0;
            idx_q   <= '0;
          end
        end
        LOW: begin
          if (rise_c) begin
            state_q <= HIGH;
          end else if (cnt_q == CNT_W'(T_RESET - 1)) begin
            frame_done_q  <= 1'b1;
            frame_leds_q  <= idx_q;
            err_partial_q <= (nbits_q != '0);
            nbits_q       <= '0;
            idx_q         <= '0;
          end
        end
        HIGH: begin
          if (fall_c) begin
            if (cnt_q < CNT_W'(T_MIN_HIGH)) begin
              err_timing_q <= 1'b1;
              state_q      <= SYNC;
              nbits_q      <= '0;
            end else begin
              shift_q <= {shift_q[RGB_W-2:0], (cnt_q >= CNT_W'(T_THRESH))};
              state_q <= LOW;
              if (nbits_q == BIT_W'(RGB_W - 1)) begin
                nbits_q <= '0;
                word_q  <= 1'b1;
              end else begin
                nbits_q <= nbits_q + BIT_W'(1);
              end
            end
          end else if (cnt_q == CNT_W'(T_MAX_HIGH - 1)) begin
            err_timing_q <= 1'b1;
            state_q      <= SYNC;
            nbits_q      <= '0;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign rgb_data    = rgb_data_q;
  assign rgb_valid   = rgb_valid_q;
  assign led_index   = led_index_q;
  assign frame_done  = frame_done_q;
  assign frame_leds  = frame_leds_q;
  assign err_timing  = err_timing_q;
  assign err_partial = err_partial_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: a pulse-level model predicts every output pulse and its
// due cycle from the widths driven on din; a per-cycle monitor checks the DUT.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  localparam int unsigned IDX_W = 9;
  localparam int IDX_MAX = (1 << IDX_W) - 1;

  logic             clk_sb = 1'b0;
  logic             reset_n = 1'b0;
  logic             din = 1'b0;
  logic [23:0]      rgb_data;
  logic             rgb_valid;
  logic [IDX_W-1:0] led_index;
  logic             frame_done;
  logic [IDX_W-1:0] frame_leds;
  logic             err_timing;
  logic             err_partial;

  ws2812_rx dut (
    .clk_sb      (clk_sb),
    .reset_n     (reset_n),
    .din         (din),
    .rgb_data    (rgb_data),
    .rgb_valid   (rgb_valid),
    .led_index   (led_index),
    .frame_done  (frame_done),
    .frame_leds  (frame_leds),
    .err_timing  (err_timing),
    .err_partial (err_partial)
  );

  always #5 clk_sb = ~clk_sb;

  int cyc = 0;
  always @(posedge clk_sb) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    int               due;
    logic [23:0]      data;
    logic [IDX_W-1:0] idx;
    logic             partial;
  } ev_t;

  ev_t q_valid[$];
  ev_t q_frame[$];
  ev_t q_errt[$];

  // Model state, expressed in terms of whole pulses on the wire
  logic        m_synced = 1'b0;
  logic [23:0] m_shift = '0;
  int          m_bits = 0;
  int          m_idx = 0;

  // Values the held outputs must show
  logic [23:0]      exp_rgb = '0;
  logic [IDX_W-1:0] exp_idx = '0;
  logic [IDX_W-1:0] exp_leds = '0;

  int n_valid = 0;
  int n_frame = 0;
  int n_errt = 0;
  int n_errp = 0;
  logic [23:0] seen_words[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A run of level v, n cycles long, first sampled at posedge p
  task automatic model_run(input logic v, input int n, input int p);
    ev_t e;
    e.data = '0;
    e.idx = '0;
    e.partial = 1'b0;
    if (v) begin
      if (m_synced) begin
        if (n >= 60) begin
          e.due = p + 60 + 1;
          q_errt.push_back(e);
          m_synced = 1'b0;
        end else if (n < 8) begin
          e.due = p + n + 2;
          q_errt.push_back(e);
          m_synced = 1'b0;
        end else begin
          m_shift = {m_shift[22:0], (n >= 29)};
          m_bits++;
          if (m_bits == 24) begin
            e.due = p + n + 3;
            e.data = m_shift;
            e.idx = IDX_W'(m_idx);
            q_valid.push_back(e);
            if (m_idx < IDX_MAX) m_idx++;
            m_bits = 0;
          end
        end
      end
    end else if (n >= 2400) begin
      if (m_synced) begin
        e.due = p + 2400 + 1;
        e.idx = IDX_W'(m_idx);
        e.partial = (m_bits != 0);
        q_frame.push_back(e);
      end
      m_synced = 1'b1;
      m_bits = 0;
      m_idx = 0;
    end
  endtask

  task automatic pin(input logic v, input int n);
    model_run(v, n, cyc + 1);
    din = v;
    repeat (n) @(negedge clk_sb);
  endtask

  task automatic pulse(input int h, input int l);
    pin(1'b1, h);
    pin(1'b0, l);
  endtask

  // First n bits of w, MSB first; a nonzero tail replaces the final low
  task automatic send_word(input logic [23:0] w, input int n, input int tail);
    logic b;
    int lo;
    for (int i = 0; i < n; i++) begin
      b = w[23 - i];
      lo = b ? int'(TBIT - T1H) : int'(TBIT - T0H);
      if (i == n - 1 && tail != 0) lo = tail;
      pulse(b ? int'(T1H) : int'(T0H), lo);
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge clk_sb);
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_frame = 0;
    n_errt = 0;
    n_errp = 0;
    seen_words.delete();
  endtask

  // Per-cycle monitor
  always @(posedge clk_sb) begin
    ev_t e;
    #1;
    while (q_valid.size() > 0 && q_valid[0].due + 1 < cyc) begin
      chk("rgb_valid missing", 32'(0), 32'(q_valid[0].due));
      void'(q_valid.pop_front());
    end
    while (q_frame.size() > 0 && q_frame[0].due + 1 < cyc) begin
      chk("frame_done missing", 32'(0), 32'(q_frame[0].due));
      void'(q_frame.pop_front());
    end
    while (q_errt.size() > 0 && q_errt[0].due + 1 < cyc) begin
      chk("err_timing missing", 32'(0), 32'(q_errt[0].due));
      void'(q_errt.pop_front());
    end

    if (rgb_valid) begin
      n_valid++;
      seen_words.push_back(rgb_data);
      if (q_valid.size() == 0 || q_valid[0].due > cyc + 1) begin
        chk("rgb_valid unexpected", 32'(1), 32'(0));
      end else begin
        e = q_valid.pop_front();
        exp_rgb = e.data;
        exp_idx = e.idx;
      end
    end
    if (frame_done) begin
      n_frame++;
      if (q_frame.size() == 0 || q_frame[0].due > cyc + 1) begin
        chk("frame_done unexpected", 32'(1), 32'(0));
      end else begin
        e = q_frame.pop_front();
        exp_leds = e.idx;
        chk("err_partial with frame", 32'(err_partial), 32'(e.partial));
      end
    end else begin
      chk("err_partial alone", 32'(err_partial), 32'(0));
    end
    if (err_partial) n_errp++;
    if (err_timing) begin
      n_errt++;
      if (q_errt.size() == 0 || q_errt[0].due > cyc + 1) begin
        chk("err_timing unexpected", 32'(1), 32'(0));
      end else begin
        void'(q_errt.pop_front());
      end
    end

    chk("rgb_data", 32'(rgb_data), 32'(exp_rgb));
    chk("led_index", 32'(led_index), 32'(exp_idx));
    chk("frame_leds", 32'(frame_leds), 32'(exp_leds));
  end

  initial begin
    repeat (3) @(negedge clk_sb);
    chk("reset rgb_data", 32'(rgb_data), 32'h0);
    chk("reset flags", 32'({rgb_valid, frame_done, err_timing, err_partial}), 32'h0);
    reset_n = 1'b1;

    // Joining mid-stream: pulses ignored, first latch silent
    clear_counts();
    pin(1'b0, 5);
    for (int i = 0; i < 30; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      pulse(b ? int'(T1H) : int'(T0H),
            (i == 29) ? 2400 : (b ? int'(TBIT - T1H) : int'(TBIT - T0H)));
    end
    settle();
    chk("sync no rgb_valid", 32'(n_valid), 32'(0));
    chk("sync no frame_done", 32'(n_frame), 32'(0));

    // Two-word frame
    clear_counts();
    send_word(24'hFF0000, 24, 0);
    send_word(24'h00A55A, 24, 2400);
    settle();
    chk("frame2 valid count", 32'(n_valid), 32'(2));
    if (seen_words.size() == 2) begin
      chk("frame2 word0", 32'(seen_words[0]), 32'hFF0000);
      chk("frame2 word1", 32'(seen_words[1]), 32'h00A55A);
    end else begin
      chk("frame2 words seen", 32'(seen_words.size()), 32'(2));
    end
    chk("frame2 led_index", 32'(led_index), 32'(1));
    chk("frame2 frame_leds", 32'(frame_leds), 32'(2));

    // Latch with 12 bits pending
    clear_counts();
    send_word(24'h0ABCDE, 12, 2400);
    settle();
    chk("partial err_partial", 32'(n_errp), 32'(1));
    chk("partial frame_done", 32'(n_frame), 32'(1));
    chk("partial frame_leds", 32'(frame_leds), 32'(0));
    chk("partial no rgb_valid", 32'(n_valid), 32'(0));

    // Glitch mid-word, resync, clean frame
    clear_counts();
    send_word(24'hC3C3C3, 8, 0);
    pulse(3, 30);
    send_word(24'hFFFFFF, 16, 2400);
    settle();
    chk("glitch err_timing", 32'(n_errt), 32'(1));
    chk("glitch no frame_done", 32'(n_frame), 32'(0));
    send_word(24'h5A5AC3, 24, 2400);
    settle();
    chk("post-glitch valid", 32'(n_valid), 32'(1));
    chk("post-glitch rgb", 32'(rgb_data), 32'h5A5AC3);
    chk("post-glitch idx", 32'(led_index), 32'(0));
    chk("post-glitch leds", 32'(frame_leds), 32'(1));

    // Overlong high
    clear_counts();
    pin(1'b1, 80);
    pin(1'b0, 2400);
    settle();
    chk("long-high err_timing", 32'(n_errt), 32'(1));
    chk("long-high no valid", 32'(n_valid), 32'(0));

    // Reset at bit 10 of word 2
    clear_counts();
    send_word(24'h111111, 24, 0);
    send_word(24'h222222, 24, 0);
    send_word(24'h333333, 10, 0);
    reset_n = 1'b0;
    q_valid.delete();
    q_frame.delete();
    q_errt.delete();
    m_synced = 1'b0;
    m_bits = 0;
    m_idx = 0;
    exp_rgb = '0;
    exp_idx = '0;
    exp_leds = '0;
    #1;
    chk("midreset rgb_data", 32'(rgb_data), 32'h0);
    chk("midreset led_index", 32'(led_index), 32'h0);
    repeat (4) @(negedge clk_sb);
    reset_n = 1'b1;
    clear_counts();
    pin(1'b0, 2500);
    send_word(24'h123456, 24, 2400);
    settle();
    chk("after reset valid", 32'(n_valid), 32'(1));
    chk("after reset rgb", 32'(rgb_data), 32'h123456);
    chk("after reset idx", 32'(led_index), 32'(0));

    // Width boundaries: 28 -> 0, 29 -> 1, 8 -> 0; low 2399 is no latch
    clear_counts();
    pulse(28, 41);
    pulse(29, 31);
    pulse(8, 52);
    send_word(24'h0F0F0F << 3, 21, 2399);
    send_word(24'hABCDEF, 24, 2400);
    settle();
    chk("boundary valid count", 32'(n_valid), 32'(2));
    if (seen_words.size() == 2) begin
      chk("boundary word0", 32'(seen_words[0]), 32'h4F0F0F);
      chk("boundary word1", 32'(seen_words[1]), 32'hABCDEF);
    end else begin
      chk("boundary words seen", 32'(seen_words.size()), 32'(2));
    end
    chk("boundary frame count", 32'(n_frame), 32'(1));
    chk("boundary frame_leds", 32'(frame_leds), 32'(2));

    repeat (10) @(negedge clk_sb);
    chk("pending events", 32'(q_valid.size() + q_frame.size() + q_errt.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
